// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for a 4x16 single-port register file.
// Turns WRITE/READ/COPY/ADD commands into regfile port cycles.
module regfile_cmd_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_src,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rf_we,
  output logic [1:0]  rf_addr,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_rdata,
  output logic        busy
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;
  localparam logic [1:0] OP_ADD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_SRC,
    RD_DST,
    WR,
    RESP
  } state_t;

  state_t      state, nxt;
  logic [1:0]  op_q;
  logic [1:0]  dst_q;
  logic [1:0]  src_q;
  logic [15:0] data_q;
  logic [15:0] tmp;
  logic        accept;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      data_q   <= '0;
      tmp      <= '0;
      rsp_data <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q   <= cmd_op;
        dst_q  <= cmd_dst;
        src_q  <= cmd_src;
        data_q <= cmd_data;
      end
      if (state == RD_SRC) tmp <= rf_rdata;
      if (state == RD_DST) tmp <= tmp + rf_rdata;
      // READ ends in RD_SRC; all other ops reach RESP from WR
      if (state == RD_SRC && op_q == OP_READ) rsp_data <= rf_rdata;
      if (state == WR) rsp_data <= rf_wdata;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) nxt = (cmd_op == OP_WRITE) ? WR : RD_SRC;
      end
      RD_SRC: begin
        unique case (op_q)
          OP_READ: nxt = RESP;
          OP_ADD:  nxt = RD_DST;
          default: nxt = WR;
        endcase
      end
      RD_DST: nxt = WR;
      WR:     nxt = RESP;
      RESP: begin
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    unique case (state)
      RD_SRC: rf_addr = src_q;
      RD_DST: rf_addr = dst_q;
      WR: begin
        rf_we    = 1'b1;
        rf_addr  = dst_q;
        rf_wdata = (op_q == OP_WRITE) ? data_q : tmp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master with a behavioural 4x16 regfile.
// Table-driven command vectors plus backpressure and reset sequences.
module tb_regfile_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_src;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rf_we;
  logic [1:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;
  logic        busy;

  logic [15:0] rf [4] = '{default: 16'h0};

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf[rf_addr] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_addr];

  regfile_cmd_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  dst;
    logic [1:0]  src;
    logic [15:0] data;
    logic [15:0] exp_rsp;
    int          exp_lat;
    int          exp_we;
    logic [1:0]  exp_a1;
    logic [1:0]  reg_idx;
    logic [15:0] reg_val;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int lat = 0;
    int wes = 0;
    logic [1:0]  a1 = '0;
    logic [1:0]  wa = '0;
    logic [15:0] wd = '0;
    @(negedge clk);
    chk({nm, " ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_dst   = v.dst;
    cmd_src   = v.src;
    cmd_data  = v.data;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a1 = rf_addr;
      if (rf_we) begin
        wes++;
        wa = rf_addr;
        wd = rf_wdata;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " rsp_data"}, {16'b0, rsp_data}, {16'b0, v.exp_rsp});
    chk({nm, " we_pulses"}, wes, v.exp_we);
    chk({nm, " first_addr"}, {30'b0, a1}, {30'b0, v.exp_a1});
    if (v.exp_we > 0) begin
      chk({nm, " wr_addr"}, {30'b0, wa}, {30'b0, v.dst});
      chk({nm, " wr_data"}, {16'b0, wd}, {16'b0, v.exp_rsp});
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, " ready_after"}, {31'b0, cmd_ready}, 32'd1);
    chk({nm, " reg"}, {16'b0, rf[v.reg_idx]}, {16'b0, v.reg_val});
  endtask

  initial begin
    vecs[0] = '{2'd0, 2'd2, 2'd0, 16'hBEEF, 16'hBEEF, 2, 1, 2'd2, 2'd2, 16'hBEEF};
    vecs[1] = '{2'd0, 2'd1, 2'd0, 16'h1234, 16'h1234, 2, 1, 2'd1, 2'd1, 16'h1234};
    vecs[2] = '{2'd1, 2'd0, 2'd1, 16'h7777, 16'h1234, 2, 0, 2'd1, 2'd1, 16'h1234};
    vecs[3] = '{2'd0, 2'd0, 2'd0, 16'h00AA, 16'h00AA, 2, 1, 2'd0, 2'd0, 16'h00AA};
    vecs[4] = '{2'd2, 2'd3, 2'd0, 16'h9999, 16'h00AA, 3, 1, 2'd0, 2'd3, 16'h00AA};
    vecs[5] = '{2'd1, 2'd0, 2'd0, 16'h0000, 16'h00AA, 2, 0, 2'd0, 2'd0, 16'h00AA};
    vecs[6] = '{2'd0, 2'd1, 2'd0, 16'hFFFF, 16'hFFFF, 2, 1, 2'd1, 2'd1, 16'hFFFF};
    vecs[7] = '{2'd0, 2'd2, 2'd0, 16'h0003, 16'h0003, 2, 1, 2'd2, 2'd2, 16'h0003};
    vecs[8] = '{2'd3, 2'd1, 2'd2, 16'h0000, 16'h0002, 4, 1, 2'd2, 2'd1, 16'h0002};
    vecs[9] = '{2'd3, 2'd2, 2'd2, 16'h0000, 16'h0006, 4, 1, 2'd2, 2'd2, 16'h0006};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_dst   = '0;
    cmd_src   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready_valid_busy", {29'b0, cmd_ready, rsp_valid, busy}, 32'b100);
    chk("reset rsp_data", {16'b0, rsp_data}, 32'h0);
    chk("reset rf_port", {13'b0, rf_we, rf_addr, rf_wdata}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold RESP, spurious commands must be ignored.
    begin
      int lat = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_dst   = 2'd0;
      cmd_data  = 16'h5A5A;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          lat = k;
          break;
        end
      end
      chk("bp latency", lat, 2);
      for (int k = 0; k < 5; k++) begin
        cmd_valid = k[0];
        cmd_op    = 2'd0;
        cmd_dst   = 2'd3;
        cmd_data  = 16'hDEAD;
        @(negedge clk);
        chk($sformatf("bp hold%0d", k),
            {13'b0, rsp_valid, cmd_ready, rf_we, rsp_data},
            {13'b0, 3'b100, 16'h5A5A});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp release", {14'b0, cmd_ready, rsp_valid, rsp_data},
          {14'b0, 2'b10, 16'h5A5A});
      chk("bp r3 untouched", {16'b0, rf[3]}, 32'h00AA);
      chk("bp r0 written", {16'b0, rf[0]}, 32'h5A5A);
    end

    // Reset during RD_DST of ADD src=2 dst=1.
    begin
      int wes = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_dst   = 2'd1;
      cmd_src   = 2'd2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst rd_src addr", {30'b0, rf_addr}, 32'd2);
      @(negedge clk);
      chk("rst rd_dst addr", {30'b0, rf_addr}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst outs", {12'b0, cmd_ready, rsp_valid, busy, rf_we, rf_addr,
                       rf_wdata}, {12'b0, 4'b1000, 2'b00, 16'h0});
      chk("rst rsp_data", {16'b0, rsp_data}, 32'h0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (rf_we) wes++;
        if (k == 1) rst_n = 1'b1;
      end
      chk("rst no_we", wes, 0);
      chk("rst r1 unchanged", {16'b0, rf[1]}, 32'h0002);
    end

    run_cmd('{2'd0, 2'd1, 2'd0, 16'h0F0F, 16'h0F0F, 2, 1, 2'd1, 2'd1, 16'h0F0F},
            "post_rst_write");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
